// File: rtl/fetch_seq_ctrl_pkg.sv
// Shared definitions for the core control sequencer: state encoding,
// default parameter values and the watchdog width helper.
package core_ctrl_pkg;

  localparam int DEFAULT_TIMEOUT_CYCLES = 16;
  localparam int DEFAULT_CNT_WIDTH      = 32;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t ST_FETCH = 3'd0;
  localparam seq_state_t ST_EXEC  = 3'd1;
  localparam seq_state_t ST_MEM   = 3'd2;
  localparam seq_state_t ST_HALT  = 3'd3;
  localparam seq_state_t ST_TRAP  = 3'd4;

  // Counter must hold TIMEOUT_CYCLES-1; never narrower than one bit.
  function automatic int timeout_w(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/fetch_seq_ctrl_if.sv
// Handshake/status bundle between the sequencer and the memory/datapath side.
interface fetch_seq_ctrl_if import core_ctrl_pkg::*; #(
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) ();

  logic                 halt_req;
  logic                 imem_ack;
  logic                 is_mem_op;
  logic                 dmem_ack;
  logic                 imem_req;
  logic                 ir_load;
  logic                 dmem_req;
  logic                 stall;
  logic                 commit;
  logic                 halted;
  logic                 bus_error;
  logic [CNT_WIDTH-1:0] instret;

  modport master (
    input  halt_req, imem_ack, is_mem_op, dmem_ack,
    output imem_req, ir_load, dmem_req, stall, commit, halted, bus_error, instret
  );

  modport slave (
    output halt_req, imem_ack, is_mem_op, dmem_ack,
    input  imem_req, ir_load, dmem_req, stall, commit, halted, bus_error, instret
  );

endinterface

// File: rtl/fetch_seq_ctrl_bus_watchdog.sv
// Wait-cycle counter for a bus master; flags the last allowed cycle
// without an acknowledge.
module bus_watchdog import core_ctrl_pkg::*; #(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic tick,
  output logic expired
);

  localparam int TIMEOUT_W = timeout_w(TIMEOUT_CYCLES);
  localparam logic [TIMEOUT_W-1:0] LAST_WAIT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      count <= '0;
    end else if (tick) begin
      count <= count + TIMEOUT_W'(1);
    end
  end

  assign expired = (count == LAST_WAIT);

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Multi-cycle fetch/execute/memory sequencer: drives bus requests, PC stall,
// IR load and commit strobes, counts retired instructions, traps on timeout.
module fetch_seq_ctrl import core_ctrl_pkg::*; #(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_WIDTH      = DEFAULT_CNT_WIDTH
) (
  input logic              clk,
  input logic              reset,
  fetch_seq_ctrl_if.master bus
);

  seq_state_t           state;
  seq_state_t           next_state;
  logic                 imem_req;
  logic                 ir_load;
  logic                 dmem_req;
  logic                 stall;
  logic                 commit;
  logic                 wd_tick;
  logic                 wd_expired;
  logic                 bus_error_q;
  logic [CNT_WIDTH-1:0] instret_q;

  // The watchdog runs only while a request is outstanding and unacked;
  // any other cycle clears it so each new request starts from zero.
  assign wd_tick = reset &&
                   (((state == ST_FETCH) && !bus.imem_ack) ||
                    ((state == ST_MEM)   && !bus.dmem_ack));

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (!wd_tick),
    .tick   (wd_tick),
    .expired(wd_expired)
  );

  always_comb begin
    next_state = state;
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    dmem_req   = 1'b0;
    stall      = 1'b1;
    commit     = 1'b0;
    if (reset) begin
      case (state)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (bus.imem_ack) begin
            ir_load    = 1'b1;
            next_state = ST_EXEC;
          end else if (wd_expired) begin
            next_state = ST_TRAP;
          end
        end
        ST_EXEC: begin
          if (bus.is_mem_op) begin
            next_state = ST_MEM;
          end else begin
            stall      = 1'b0;
            commit     = 1'b1;
            next_state = bus.halt_req ? ST_HALT : ST_FETCH;
          end
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          if (bus.dmem_ack) begin
            stall      = 1'b0;
            commit     = 1'b1;
            next_state = bus.halt_req ? ST_HALT : ST_FETCH;
          end else if (wd_expired) begin
            next_state = ST_TRAP;
          end
        end
        ST_HALT: begin
          if (!bus.halt_req) begin
            next_state = ST_FETCH;
          end
        end
        ST_TRAP: begin
          next_state = ST_TRAP;
        end
        default: begin
          next_state = ST_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_FETCH;
      instret_q   <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state <= next_state;
      if (commit) begin
        instret_q <= instret_q + CNT_WIDTH'(1);
      end
      if (next_state == ST_TRAP) begin
        bus_error_q <= 1'b1;
      end
    end
  end

  assign bus.imem_req  = imem_req;
  assign bus.ir_load   = ir_load;
  assign bus.dmem_req  = dmem_req;
  assign bus.stall     = stall;
  assign bus.commit    = commit;
  assign bus.halted    = reset && (state == ST_HALT);
  assign bus.bus_error = bus_error_q;
  assign bus.instret   = instret_q;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Self-checking bench for fetch_seq_ctrl: cycle-level stimulus with a
// scoreboard of expected retired-instruction counts.
module tb_fetch_seq_ctrl;
  import core_ctrl_pkg::*;

  localparam int CW = 4;

  // Output vector order: imem_req, ir_load, dmem_req, stall, commit, halted, bus_error
  localparam logic [6:0] O_RESET     = 7'b0001000;
  localparam logic [6:0] O_FETCH     = 7'b1001000;
  localparam logic [6:0] O_FETCH_ACK = 7'b1101000;
  localparam logic [6:0] O_EXEC_CMT  = 7'b0000100;
  localparam logic [6:0] O_EXEC_MEM  = 7'b0001000;
  localparam logic [6:0] O_MEM_WAIT  = 7'b0011000;
  localparam logic [6:0] O_MEM_ACK   = 7'b0010100;
  localparam logic [6:0] O_HALT      = 7'b0001010;
  localparam logic [6:0] O_TRAP      = 7'b0001001;

  logic          clk = 1'b0;
  logic          reset;
  logic          rst_level;
  int            checks;
  int            failures;
  logic [CW-1:0] exp_instret;
  logic [CW-1:0] sb_q[$];

  fetch_seq_ctrl_if #(.CNT_WIDTH(CW)) bus ();

  fetch_seq_ctrl #(
    .TIMEOUT_CYCLES(16),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {bus.imem_req, bus.ir_load, bus.dmem_req, bus.stall,
            bus.commit, bus.halted, bus.bus_error};
  endfunction

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic h, input logic ia, input logic mo, input logic da);
    @(negedge clk);
    reset         = rst_level;
    bus.halt_req  = h;
    bus.imem_ack  = ia;
    bus.is_mem_op = mo;
    bus.dmem_ack  = da;
    #1;
  endtask

  task automatic do_instr(input string tag, input bit is_mem, input int iwait, input int dwait);
    logic [CW-1:0] exp;
    for (int i = 0; i < iwait; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      checks++;
      if (outs() !== O_FETCH) begin
        failures++;
        $display("[TB] FAIL %s fetch_wait%0d outs actual=%b expected=%b", tag, i, outs(), O_FETCH);
      end
    end
    exp_instret = exp_instret + 1'b1;
    sb_q.push_back(exp_instret);
    drive(1'b0, 1'b1, is_mem, 1'b0);
    checks++;
    if (outs() !== O_FETCH_ACK) begin
      failures++;
      $display("[TB] FAIL %s fetch_ack outs actual=%b expected=%b", tag, outs(), O_FETCH_ACK);
    end
    if (!is_mem) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (outs() !== O_EXEC_CMT) begin
        failures++;
        $display("[TB] FAIL %s exec_commit outs actual=%b expected=%b", tag, outs(), O_EXEC_CMT);
      end
    end else begin
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (outs() !== O_EXEC_MEM) begin
        failures++;
        $display("[TB] FAIL %s exec_mem outs actual=%b expected=%b", tag, outs(), O_EXEC_MEM);
      end
      for (int i = 0; i < dwait; i++) begin
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (outs() !== O_MEM_WAIT) begin
          failures++;
          $display("[TB] FAIL %s mem_wait%0d outs actual=%b expected=%b", tag, i, outs(), O_MEM_WAIT);
        end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (outs() !== O_MEM_ACK) begin
        failures++;
        $display("[TB] FAIL %s mem_ack outs actual=%b expected=%b", tag, outs(), O_MEM_ACK);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    exp = sb_q.pop_front();
    checks++;
    if (outs() !== O_FETCH || bus.instret !== exp) begin
      failures++;
      $display("[TB] FAIL %s after_commit outs=%b instret=%0d expected outs=%b instret=%0d",
               tag, outs(), bus.instret, O_FETCH, exp);
    end
  endtask

  task automatic test_reset();
    rst_level = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1);
      checks++;
      if (outs() !== O_RESET || bus.instret !== '0) begin
        failures++;
        $display("[TB] FAIL reset%0d outs=%b instret=%0d expected outs=%b instret=0",
                 i, outs(), bus.instret, O_RESET);
      end
    end
    rst_level   = 1'b1;
    exp_instret = '0;
  endtask

  task automatic test_first_cycle_ack();
    do_instr("first_ack", 1'b0, 0, 0);
  endtask

  task automatic test_mem_delay();
    do_instr("mem_delay4", 1'b1, 2, 4);
  endtask

  task automatic test_halt();
    logic [CW-1:0] exp;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    exp_instret = exp_instret + 1'b1;
    sb_q.push_back(exp_instret);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs() !== O_EXEC_CMT) begin
      failures++;
      $display("[TB] FAIL halt_commit outs actual=%b expected=%b", outs(), O_EXEC_CMT);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      checks++;
      if (outs() !== O_HALT) begin
        failures++;
        $display("[TB] FAIL halt_hold%0d outs actual=%b expected=%b", i, outs(), O_HALT);
      end
    end
    exp = sb_q.pop_front();
    checks++;
    if (bus.instret !== exp) begin
      failures++;
      $display("[TB] FAIL halt_instret actual=%0d expected=%0d", bus.instret, exp);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs() !== O_HALT) begin
      failures++;
      $display("[TB] FAIL halt_release outs actual=%b expected=%b", outs(), O_HALT);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs() !== O_FETCH) begin
      failures++;
      $display("[TB] FAIL halt_resume outs actual=%b expected=%b", outs(), O_FETCH);
    end
  endtask

  // Entered with one FETCH wait already spent, so 14 more puts the ack on cycle 16.
  task automatic test_ack_at_limit();
    do_instr("fetch_ack_cyc16", 1'b0, 14, 0);
    do_instr("mem_ack_cyc16", 1'b1, 0, 15);
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (outs() !== O_FETCH) begin
        failures++;
        $display("[TB] FAIL timeout_fetch%0d outs actual=%b expected=%b", i, outs(), O_FETCH);
      end
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      checks++;
      if (outs() !== O_TRAP || bus.instret !== exp_instret) begin
        failures++;
        $display("[TB] FAIL trap%0d outs=%b instret=%0d expected outs=%b instret=%0d",
                 i, outs(), bus.instret, O_TRAP, exp_instret);
      end
    end
    rst_level = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs() !== O_RESET || bus.instret !== '0) begin
      failures++;
      $display("[TB] FAIL trap_reset outs=%b instret=%0d expected outs=%b instret=0",
               outs(), bus.instret, O_RESET);
    end
    rst_level   = 1'b1;
    exp_instret = '0;
  endtask

  task automatic test_reset_mid_mem();
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs() !== O_MEM_WAIT) begin
      failures++;
      $display("[TB] FAIL midmem_wait outs actual=%b expected=%b", outs(), O_MEM_WAIT);
    end
    rst_level = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (outs() !== O_RESET) begin
      failures++;
      $display("[TB] FAIL midmem_reset outs actual=%b expected=%b", outs(), O_RESET);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    rst_level = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs() !== O_FETCH || bus.instret !== '0) begin
      failures++;
      $display("[TB] FAIL midmem_release outs=%b instret=%0d expected outs=%b instret=0",
               outs(), bus.instret, O_FETCH);
    end
    exp_instret = '0;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 15; i++) begin
      do_instr("wrap_fill", 1'b0, 0, 0);
    end
    checks++;
    if (bus.instret !== 4'hF) begin
      failures++;
      $display("[TB] FAIL wrap_preload actual=%0d expected=15", bus.instret);
    end
    do_instr("wrap_last", 1'b0, 0, 0);
    checks++;
    if (bus.instret !== 4'h0) begin
      failures++;
      $display("[TB] FAIL wrap_zero actual=%0d expected=0", bus.instret);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    exp_instret   = '0;
    rst_level     = 1'b0;
    reset         = 1'b0;
    bus.halt_req  = 1'b0;
    bus.imem_ack  = 1'b0;
    bus.is_mem_op = 1'b0;
    bus.dmem_ack  = 1'b0;
    test_reset();
    test_first_cycle_ack();
    test_mem_delay();
    test_halt();
    test_ack_at_limit();
    test_timeout();
    test_reset_mid_mem();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL global_timeout simulation exceeded 50000ns");
    $fatal(1, "[TB] run did not complete");
  end

endmodule

// File: doc/fetch_seq_ctrl.md
Name: fetch_seq_ctrl

Overview:
- Multi-cycle sequencer for the single-issue core.
- Issues instruction-memory and data-memory requests, and generates the `stall` input that gates PC update in the PC/branch unit.
- Produces the instruction-register load strobe and the commit strobe, and keeps a retired-instruction counter.
- Handles halt requests and detects bus timeouts, trapping to a sticky error state.

Parameters:
- `TIMEOUT_CYCLES`, 16, wait cycles without ack before bus error (≥2).
- `CNT_WIDTH`, 32, retired-instruction counter width.

Ports:
- `clk`  in  1  core clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-low reset (asserted when 0).
- `halt_req`  in  1  request to pause at the next instruction boundary.
- `imem_ack`  in  1  instruction word valid this cycle; meaningful only while `imem_req`=1.
- `is_mem_op`  in  1  decoded instruction is a load/store; valid in EXEC.
- `dmem_ack`  in  1  data access complete; meaningful only while `dmem_req`=1.
- `imem_req`  out  1  instruction fetch request.
- `ir_load`  out  1  load instruction register this cycle.
- `dmem_req`  out  1  data memory request.
- `stall`  out  1  1 = hold PC; 0 = PC takes `pc_next` at the clock edge.
- `commit`  out  1  instruction retires this cycle (register-file write enable gate).
- `halted`  out  1  in HALT state.
- `bus_error`  out  1  sticky timeout flag.
- `instret`  out  CNT_WIDTH  retired-instruction count.

Behaviour:
- **States:** FETCH, EXEC, MEM, HALT, TRAP. Encoding lives in the package.
- **Reset** (`reset`=0 at an edge):
  - state←FETCH, wait counter←0, `instret`←0, `bus_error`←0.
  - While `reset`=0, all request/strobe outputs are forced 0 and `stall`=1.
  - Reset mid-transaction abandons the transaction; no commit.
- **FETCH:**
  - `imem_req`=1, `stall`=1.
  - On `imem_ack`=1: `ir_load`=1 in the same cycle (Mealy), next state EXEC, counter←0.
  - Otherwise counter+1.
  - Ack in the first FETCH cycle is legal.
- **EXEC:**
  - If `is_mem_op`=0: `stall`=0, `commit`=1 for exactly this cycle. Next state is HALT if `halt_req`=1, else FETCH.
  - If `is_mem_op`=1: `stall`=1, no commit, next state MEM, counter←0.
- **MEM:**
  - `dmem_req`=1.
  - `stall`=~`dmem_ack`, `commit`=`dmem_ack` (Mealy).
  - On ack: next state is HALT if `halt_req`=1, else FETCH.
  - Without ack: counter+1.
- **HALT:**
  - `stall`=1, `halted`=1, no requests.
  - When `halt_req`=0, next state FETCH.
  - `halt_req` is sampled only at commit boundaries and in HALT.
- **Timeout:**
  - Applies in FETCH/MEM: when the counter equals `TIMEOUT_CYCLES`-1 and no ack arrives this cycle, next state TRAP.
  - An ack arriving in that same cycle wins; the transition is normal.
- **TRAP:** `bus_error`=1, `stall`=1, all requests 0. Left only by reset.
- **Latency:**
  - Non-memory instruction: 2 cycles minimum (FETCH with ack, EXEC).
  - Memory instruction: 3 cycles minimum.
- **Invariants:**
  - Exactly one `commit` per instruction.
  - `stall`=0 only in commit cycles, so the PC advances exactly once per retired instruction.
- **Requests:**
  - `imem_req`/`dmem_req` are never both 1.
  - A request stays asserted until acked (no withdraw).
- **`instret`:** increments by 1 on each `commit`; wraps from all-ones to 0.
- **Ack outside its state:** `imem_ack`/`dmem_ack` outside FETCH/MEM respectively is ignored.

Decomposition:
- Package `core_ctrl_pkg` holds:
  - state enum `seq_state_t`;
  - `TIMEOUT_W` = `$clog2(TIMEOUT_CYCLES)` helper function;
  - default parameter constants.
- Sub-module `bus_watchdog` holds the wait counter: inputs `clr` and `tick`, output `expired`. It is reused for future bus masters.
- FSM and `instret` stay in the top module.

Test Plan:
- Reset low 3 cycles, release; `imem_ack`=1 in the first FETCH cycle with `is_mem_op`=0 → `ir_load` cycle 1, `stall`=0 and `commit`=1 in cycle 2, `instret`=1.
- Memory op with `dmem_ack` delayed 4 cycles → MEM lasts 5 cycles, `stall`=1 throughout except the ack cycle, one `commit`, `instret`+1.
- `imem_ack` never returns, `TIMEOUT_CYCLES`=16 → TRAP entered after cycle 16 of FETCH, `bus_error`=1 sticky, requests 0; reset clears it.
- Ack exactly on cycle 16 → no TRAP, normal EXEC.
- `halt_req`=1 during an EXEC commit → HALT next cycle, no `imem_req` for 10 cycles; drop `halt_req` → FETCH resumes next cycle.
- Preload `instret` near wrap: 4'hF with `CNT_WIDTH`=4, one commit → `instret`=0.
- Reset asserted mid-MEM → no commit, state FETCH after release, `instret`=0.
